// File: rtl/calc_sequencer.sv
// Multicycle instruction sequencer: fetches from an external program ROM, decodes a small
// R/I-type subset and drives an external register file and ALU, one state per cycle.
module calc_sequencer #(
  parameter int W = 32,
  parameter int L = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 opera,
  input  logic [4:0]           read,
  output logic [W-1:0]         data,
  output logic                 busy,
  output logic                 error,
  output logic [$clog2(L):0]   retired,
  output logic [$clog2(L)-1:0] rom_address,
  output logic                 rom_oe,
  input  logic [W-1:0]         rom_data,
  output logic [4:0]           Read1,
  output logic [4:0]           Read2,
  output logic [4:0]           WriteReg,
  output logic [W-1:0]         WriteData,
  output logic                 RegWrite,
  input  logic [W-1:0]         Data1,
  input  logic [W-1:0]         Data2,
  output logic [3:0]           ALUctl,
  output logic [W-1:0]         A,
  output logic [W-1:0]         B,
  input  logic [W-1:0]         ALUout
);
  localparam int AW = $clog2(L);
  localparam int RW = AW + 1;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [W-1:0]  ir_q, ir_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  data_q, data_d;
  logic [RW-1:0] retired_q, retired_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          rom_oe_q, rom_oe_d;
  logic          regwrite_q, regwrite_d;

  logic          is_r, is_i, f3_ok, legal, parked;
  logic [3:0]    alu_ctl;
  logic [W-1:0]  imm_sext;

  // Instruction decode works straight off IR, which is stable from DECODE to WRITEBACK.
  always_comb begin
    is_r    = (ir_q[6:0] == OP_R);
    is_i    = (ir_q[6:0] == OP_I);
    alu_ctl = 4'b0000;
    f3_ok   = 1'b1;
    case (ir_q[14:12])
      3'b000:  alu_ctl = (is_r && ir_q[30]) ? 4'b0110 : 4'b0010;
      3'b110:  alu_ctl = 4'b0001;
      3'b111:  alu_ctl = 4'b0000;
      3'b010:  alu_ctl = 4'b0111;
      default: f3_ok = 1'b0;
    endcase
    legal = (is_r || is_i) && f3_ok;
  end

  assign imm_sext = {{(W-12){ir_q[31]}}, ir_q[31:20]};
  assign parked   = (state_q == S_IDLE) || (state_q == S_HALT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    retired_d = retired_q;
    error_d   = error_q;
    data_d    = parked ? Data1 : data_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (opera) begin
          pc_d      = '0;
          retired_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == '0) begin
          state_d = S_HALT;
        end else if (!legal) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        a_d     = Data1;
        b_d     = is_r ? Data2 : imm_sext;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retired_d = retired_q + RW'(1);
        if (pc_q == AW'(L - 1)) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
    rom_oe_d   = (state_d == S_FETCH);
    regwrite_d = (state_d == S_WRITEBACK) && (ir_q[11:7] != 5'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      retired_q  <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      rom_oe_q   <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      retired_q  <= retired_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      rom_oe_q   <= rom_oe_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Reset gates the write strobe combinationally so a write in flight never lands.
  assign RegWrite    = regwrite_q & ~reset;
  assign data        = data_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign retired     = retired_q;
  assign rom_address = pc_q;
  assign rom_oe      = rom_oe_q;
  assign Read1       = parked ? read : ir_q[19:15];
  assign Read2       = ir_q[24:20];
  assign WriteReg    = ir_q[11:7];
  assign WriteData   = ALUout;
  assign ALUctl      = alu_ctl;
  assign A           = a_q;
  assign B           = b_q;
endmodule
